// File: rtl/vga_timing_core.sv
// Raster timing generator: scan position, sync pulses, active-video flag, line/frame strobes
// and a wrapping frame counter. Default timing is 640x480 @ 60 Hz.
module vga_timing_core #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_NEG  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotal     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_DISPLAY + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_DISPLAY + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
  localparam bit          SyncInv    = (SYNC_NEG != 0);

  localparam logic [9:0] HLast = 10'(HTotal - 1);
  localparam logic [9:0] VLast = 10'(VTotal - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       running_q, running_d;
  logic       hsync_act, vsync_act;

  // The first released edge only arms the scan, so position 0,0 is presented as a full cycle.
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    running_d     = 1'b1;
    if (running_q) begin
      if (hpos_q == HLast) begin
        hpos_d = 10'd0;
        if (vpos_q == VLast) begin
          vpos_d        = 10'd0;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q        <= 10'd0;
      vpos_q        <= 10'd0;
      frame_count_q <= 8'd0;
      running_q     <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      running_q     <= running_d;
    end
  end

  always_comb begin
    hsync_act   = running_q && (hpos_q >= 10'(HSyncStart)) && (hpos_q < 10'(HSyncEnd));
    vsync_act   = running_q && (vpos_q >= 10'(VSyncStart)) && (vpos_q < 10'(VSyncEnd));
    hsync       = hsync_act ^ SyncInv;
    vsync       = vsync_act ^ SyncInv;
    display_on  = running_q && (hpos_q < 10'(H_DISPLAY)) && (vpos_q < 10'(V_DISPLAY));
    line_start  = running_q && (hpos_q == 10'd0);
    frame_start = running_q && (hpos_q == 10'd0) && (vpos_q == 10'd0);
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a default-timing instance and a small-override instance share one
// reset; outputs are compared every cycle against a position model derived from elapsed cycles.
module tb_vga_timing_core;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       disp;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } vout_t;

  logic clk;
  logic rst_n;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic       d_hsync, d_vsync, d_disp, d_ls, d_fs;
  logic       s_hsync, s_vsync, s_disp, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;

  int n_checks = 0;
  int n_errors = 0;

  localparam int SmallFrame = 84;
  localparam int NRun       = 256 * SmallFrame;

  vga_timing_core u_dflt (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .display_on  (d_disp),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing_core #(
    .H_DISPLAY (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_NEG  (0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_disp),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: whether scanning has started, and how many scan edges have elapsed since.
  bit m_init = 1'b0;
  bit m_run  = 1'b0;
  int m_k    = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init <= 1'b1;
      m_run  <= 1'b0;
      m_k    <= 0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic vout_t model(bit run, int k, int hd, int hf, int hs, int hb,
                                  int vd, int vf, int vs, int vb, bit neg);
    vout_t o;
    int ht, vt, h, v, f;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    f  = (k / (ht * vt)) % 256;
    o.hpos  = 10'(h);
    o.vpos  = 10'(v);
    o.fc    = 8'(f);
    o.hsync = (run && h >= hd + hf && h < hd + hf + hs) ^ neg;
    o.vsync = (run && v >= vd + vf && v < vd + vf + vs) ^ neg;
    o.disp  = run && h < hd && v < vd;
    o.ls    = run && h == 0;
    o.fs    = run && h == 0 && v == 0;
    return o;
  endfunction

  always @(negedge clk) begin
    vout_t ed, es, ad, as_;
    if (m_init) begin
      ed  = model(m_run, m_k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
      es  = model(m_run, m_k, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0);
      ad  = {d_hpos, d_vpos, d_hsync, d_vsync, d_disp, d_ls, d_fs, d_fc};
      as_ = {s_hpos, s_vpos, s_hsync, s_vsync, s_disp, s_ls, s_fs, s_fc};
      n_checks += 2;
      if (ad !== ed) begin
        n_errors++;
        $display("FAIL model_dflt k=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 m_k, ad.hpos, ad.vpos, ad.hsync, ad.vsync, ad.disp, ad.ls, ad.fs, ad.fc,
                 ed.hpos, ed.vpos, ed.hsync, ed.vsync, ed.disp, ed.ls, ed.fs, ed.fc);
      end
      if (as_ !== es) begin
        n_errors++;
        $display("FAIL model_small k=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 m_k, as_.hpos, as_.vpos, as_.hsync, as_.vsync, as_.disp, as_.ls, as_.fs, as_.fc,
                 es.hpos, es.vpos, es.hsync, es.vsync, es.disp, es.ls, es.fs, es.fc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on the negedge where rst_n has just been released.
  task automatic release_checks();
    check("rel_hpos", 32'(d_hpos), 0);
    check("rel_vpos", 32'(d_vpos), 0);
    check("rel_disp", 32'(d_disp), 0);
    check("rel_hsync", 32'(d_hsync), 1);
    check("rel_vsync", 32'(d_vsync), 1);
    check("rel_small_hsync", 32'(s_hsync), 0);
    @(negedge clk);
    check("run0_fs", 32'(d_fs), 1);
    check("run0_ls", 32'(d_ls), 1);
    check("run0_disp", 32'(d_disp), 1);
    check("run0_small_fs", 32'(s_fs), 1);
  endtask

  initial begin
    int hs_lo, de_cnt, ls_mid, vs_cnt, fs_cnt;
    hs_lo = 0; de_cnt = 0; ls_mid = 0; vs_cnt = 0; fs_cnt = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    release_checks();

    for (int i = 0; i <= NRun; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 800) begin
        if (d_hsync == 1'b0) hs_lo++;
        if (d_disp) de_cnt++;
        if (i > 0 && d_ls) ls_mid++;
      end
      if (i == 800) check("dflt_ls_800", 32'(d_ls), 1);
      if (i < SmallFrame && s_vsync) vs_cnt++;
      if (s_fs) fs_cnt++;
      if (i == 9) check("small_hsync_h9", 32'(s_hsync), 1);
      if (i == 11) check("small_hsync_h11", 32'(s_hsync), 0);
      if (i == SmallFrame - 1) check("small_fc_pre1", 32'(s_fc), 0);
      if (i == SmallFrame) begin
        check("small_fs_84", 32'(s_fs), 1);
        check("small_fc_1", 32'(s_fc), 1);
      end
      if (i == NRun - 1) check("small_fc_255", 32'(s_fc), 255);
      if (i == NRun) check("small_fc_wrap", 32'(s_fc), 0);
    end
    check("dflt_hsync_low_cnt", 32'(hs_lo), 96);
    check("dflt_de_cnt", 32'(de_cnt), 640);
    check("dflt_ls_extra", 32'(ls_mid), 0);
    check("small_vsync_cnt", 32'(vs_cnt), 12);
    check("small_fs_cnt", 32'(fs_cnt), 257);

    // Mid-frame reset at small hpos=5, vpos=3.
    repeat (41) @(negedge clk);
    check("mid_hpos", 32'(s_hpos), 5);
    check("mid_vpos", 32'(s_vpos), 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hpos", 32'(s_hpos), 0);
    check("mid_rst_vpos", 32'(s_vpos), 0);
    check("mid_rst_fc", 32'(d_fc), 0);
    check("mid_rst_disp", 32'(s_disp), 0);
    rst_n = 1'b1;
    release_checks();

    repeat (20) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
